// File: rtl/mag_comp_sweep_checker.sv
// Self-checking sweep engine for a WIDTH-bit magnitude comparator: walks every (A,B)
// pair A-major/B-minor, samples the comparator flags and records errors for BIST.
module mag_comp_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             AgtB,
    input  logic             AltB,
    input  logic             AeqB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [2:0]       first_err_flags
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WIDTH-1:0] OP_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]      err_q, err_d;
    logic [WIDTH-1:0] fe_a_q, fe_a_d, fe_b_q, fe_b_d;
    logic [2:0]       fe_flags_q, fe_flags_d;
    logic [2:0]       flags_s;
    logic             mismatch_s;

    function automatic logic [2:0] expected_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {a > b, a < b, a == b};
    endfunction

    assign flags_s    = {AgtB, AltB, AeqB};
    assign mismatch_s = (flags_s != expected_flags(a_q, b_q));

    // Next-state, operand advance and error bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fe_a_d     = fe_a_q;
        fe_b_d     = fe_b_q;
        fe_flags_d = fe_flags_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d        = {WIDTH{1'b0}};
                    b_d        = {WIDTH{1'b0}};
                    err_d      = 16'd0;
                    fe_a_d     = {WIDTH{1'b0}};
                    fe_b_d     = {WIDTH{1'b0}};
                    fe_flags_d = 3'b000;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = CW'(SETTLE);
                    state_d    = S_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end else begin
                        err_d = err_q;
                    end
                    if (err_q == 16'd0) begin
                        fe_a_d     = a_q;
                        fe_b_d     = b_q;
                        fe_flags_d = flags_s;
                    end else begin
                        fe_flags_d = fe_flags_q;
                    end
                end else begin
                    err_d = err_q;
                end
                // The last vector leaves A/B parked on (max,max) for inspection.
                if ((a_q == OP_MAX) && (b_q == OP_MAX)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 16'd0);
                    state_d = S_DONE;
                end else begin
                    if (b_q == OP_MAX) begin
                        b_d = {WIDTH{1'b0}};
                        a_d = a_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        b_d = b_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    cnt_d   = CW'(SETTLE);
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 16'd0;
            fe_a_q     <= {WIDTH{1'b0}};
            fe_b_q     <= {WIDTH{1'b0}};
            fe_flags_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fe_a_q     <= fe_a_d;
            fe_b_q     <= fe_b_d;
            fe_flags_q <= fe_flags_d;
        end
    end

    assign A               = a_q;
    assign B               = b_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_flags = fe_flags_q;

endmodule

// File: tb/tb_mag_comp_sweep_checker.sv
// Bench: two checkers (SETTLE=1 and SETTLE=3) facing bench-modelled comparators with
// selectable faults; a vector-index model predicts every output on every cycle.
module tb_mag_comp_sweep_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] start_s = 2'b00;
    logic [3:0] a_o [2];
    logic [3:0] b_o [2];
    logic [2:0] flg [2];
    logic [1:0] busy_o, done_o, pass_o;
    logic [15:0] err_o [2];
    logic [3:0] fa_o [2];
    logic [3:0] fb_o [2];
    logic [2:0] ff_o [2];

    int mode [2] = '{0, 0};
    logic [2:0] lut [256];
    int total = 0;
    int bad = 0;

    // expected-state model, indexed per instance
    int          m_t [2] = '{0, 0};
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_pass [2] = '{1'b0, 1'b0};
    logic [15:0] m_err [2] = '{16'd0, 16'd0};
    logic [3:0]  m_a [2] = '{4'd0, 4'd0};
    logic [3:0]  m_b [2] = '{4'd0, 4'd0};
    logic [3:0]  m_fa [2] = '{4'd0, 4'd0};
    logic [3:0]  m_fb [2] = '{4'd0, 4'd0};
    logic [2:0]  m_ff [2] = '{3'd0, 3'd0};

    always #5 clk = ~clk;

    mag_comp_sweep_checker #(.WIDTH(4), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .A(a_o[0]), .B(b_o[0]),
        .AgtB(flg[0][2]), .AltB(flg[0][1]), .AeqB(flg[0][0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
        .first_err_a(fa_o[0]), .first_err_b(fb_o[0]), .first_err_flags(ff_o[0]));

    mag_comp_sweep_checker #(.WIDTH(4), .SETTLE(3)) u1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .A(a_o[1]), .B(b_o[1]),
        .AgtB(flg[1][2]), .AltB(flg[1][1]), .AeqB(flg[1][0]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
        .first_err_a(fa_o[1]), .first_err_b(fb_o[1]), .first_err_flags(ff_o[1]));

    function automatic logic [2:0] golden(input int a, input int b);
        return {a > b, a < b, a == b};
    endfunction

    function automatic logic [2:0] stim_flags(input int md, input int a, input int b);
        logic [2:0] g;
        g = golden(a, b);
        case (md)
            1:       return g & 3'b011;
            2:       return g | 3'b001;
            3:       return lut[a * 16 + b];
            default: return g;
        endcase
    endfunction

    // comparators under test, with injectable faults
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flg[i] = stim_flags(mode[i], int'(a_o[i]), int'(b_o[i]));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is t cycles old; vector k completes when t reaches (k+1)*(SETTLE+1).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p, nt, k;
            logic [2:0] g, f;
            logic [15:0] e;
            p = (i == 1) ? 4 : 2;
            if (reset) begin
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_pass[i] <= 1'b0;
                m_err[i] <= 16'd0; m_a[i] <= 4'd0; m_b[i] <= 4'd0;
                m_fa[i] <= 4'd0; m_fb[i] <= 4'd0; m_ff[i] <= 3'd0; m_t[i] <= 0;
            end else if (start_s[i] && !m_busy[i]) begin
                m_busy[i] <= 1'b1; m_done[i] <= 1'b0; m_pass[i] <= 1'b0;
                m_err[i] <= 16'd0; m_a[i] <= 4'd0; m_b[i] <= 4'd0;
                m_fa[i] <= 4'd0; m_fb[i] <= 4'd0; m_ff[i] <= 3'd0; m_t[i] <= 0;
            end else if (m_busy[i]) begin
                nt = m_t[i] + 1;
                m_t[i] <= nt;
                if (nt % p == 0) begin
                    k = nt / p - 1;
                    g = golden(k / 16, k % 16);
                    f = stim_flags(mode[i], k / 16, k % 16);
                    e = m_err[i];
                    if (f != g) begin
                        if (e == 16'd0) begin
                            m_fa[i] <= 4'(k / 16); m_fb[i] <= 4'(k % 16); m_ff[i] <= f;
                        end
                        if (e != 16'hFFFF) e = e + 16'd1;
                    end
                    m_err[i] <= e;
                    if (k == 255) begin
                        m_busy[i] <= 1'b0; m_done[i] <= 1'b1; m_pass[i] <= (e == 16'd0);
                    end else begin
                        m_a[i] <= 4'((k + 1) / 16); m_b[i] <= 4'((k + 1) % 16);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cycle_inst%0d", i),
                  {26'd0, a_o[i], b_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], fa_o[i], fb_o[i], ff_o[i]},
                  {26'd0, m_a[i], m_b[i], m_busy[i], m_done[i], m_pass[i], m_err[i], m_fa[i], m_fb[i], m_ff[i]});
        end
    end

    // Start a sweep on instance i; optionally poke start (kind 1) or reset (kind 2) at cycle poke_at.
    task automatic run_sweep(input int i, input int poke_at, input int poke_kind, input int exp_busy);
        int n, bc;
        bit fin;
        @(negedge clk); start_s[i] = 1'b1;
        @(negedge clk); start_s[i] = 1'b0;
        n = 0; bc = 0; fin = 1'b0;
        while (!fin && n < 5000) begin
            if (n == poke_at) begin
                if (poke_kind == 1) start_s[i] = 1'b1;
                else if (poke_kind == 2) reset = 1'b1;
            end
            if (poke_kind == 2 && n == poke_at + 1) begin
                reset = 1'b0;
                check("rst_mid_busy", busy_o[i], 1'b0);
                check("rst_mid_ab", {a_o[i], b_o[i]}, 8'h00);
                check("rst_mid_err", err_o[i], 16'd0);
                check("rst_mid_done", done_o[i], 1'b0);
                fin = 1'b1;
            end else begin
                if (n == poke_at + 1) start_s[i] = 1'b0;
                if (busy_o[i]) bc++;
                if (done_o[i]) fin = 1'b1;
                if (!fin) begin
                    @(negedge clk);
                    n++;
                end
            end
        end
        if (!fin) check("sweep_timeout", 64'd0, 64'd1);
        else if (poke_kind != 2) check($sformatf("busy_cycles_inst%0d", i), bc, exp_busy);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) lut[k] = 3'($urandom_range(0, 7));
        repeat (3) @(negedge clk);
        check("reset_busy_done", {busy_o, done_o}, 4'b0000);
        check("reset_err", err_o[0], 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // golden sweeps, both settle values
        run_sweep(0, -10, 0, 512);
        check("t1_pass", pass_o[0], 1'b1);
        check("t1_err", err_o[0], 16'd0);
        check("t1_first", {fa_o[0], fb_o[0], ff_o[0]}, 11'd0);
        run_sweep(1, -10, 0, 1024);
        check("t6_pass", pass_o[1], 1'b1);
        check("t6_last_ab", {a_o[1], b_o[1]}, 8'hFF);

        mode[0] = 1;
        run_sweep(0, -10, 0, 512);
        check("t2_err", err_o[0], 16'd120);
        check("t2_pass", pass_o[0], 1'b0);
        check("t2_first", {fa_o[0], fb_o[0], ff_o[0]}, {4'h1, 4'h0, 3'b000});

        mode[0] = 2;
        run_sweep(0, -10, 0, 512);
        check("t3_err", err_o[0], 16'd240);
        check("t3_first", {fa_o[0], fb_o[0], ff_o[0]}, {4'h0, 4'h1, 3'b011});

        mode[0] = 0;
        run_sweep(0, 100, 1, 512);
        check("t4_pass", pass_o[0], 1'b1);
        check("t4_err", err_o[0], 16'd0);

        run_sweep(0, 200, 2, 0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        run_sweep(0, -10, 0, 512);
        check("t5_pass", pass_o[0], 1'b1);

        // reset and start in the same cycle: reset wins
        reset = 1'b1; start_s[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0; start_s[0] = 1'b0;
        check("rst_start_busy", busy_o[0], 1'b0);
        check("rst_start_done", done_o[0], 1'b0);

        // random faulty comparators and random restart pokes
        for (int r = 0; r < 3; r++) begin
            mode[0] = 3;
            mode[1] = (r == 1) ? 3 : 0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            fork
                run_sweep(0, int'($urandom_range(0, 500)), 1, 512);
                run_sweep(1, int'($urandom_range(0, 1000)), 1, 1024);
            join
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
